// File: rtl/instr_mem_loader.sv
// Instruction memory loader.
// Accepts a byte stream of the form {len[7:0], len[15:8], payload[0..len-1], checksum}
// and writes the payload into a byte-wide instruction memory image. Address 0 of the
// image corresponds to the CPU reset vector 0xBFC00000, and payload bytes land in stream
// order, so the fetch side sees little-endian words.
// The CPU is held in reset (cpu_rst_n low) until a complete image with a matching
// 8-bit additive checksum has been received.
// Only MEM_BYTES = 4096 is supported because the memory is addressed by bytes_loaded[11:0].
module instr_mem_loader #(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    input  logic        reload,
    output logic [7:0]  Instr_memory [0:MEM_BYTES-1],
    output logic        load_done,
    output logic        load_err,
    output logic        cpu_rst_n,
    output logic [12:0] bytes_loaded
);

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        LOAD,
        CHK,
        DONE,
        ERR
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] len;
    logic [7:0]  sum;
    logic        xfer;
    logic [15:0] hdr_len;
    logic        hdr_bad;
    logic        last_byte;

    // Handshake and decode helpers shared by the next-state logic and the datapath.
    always_comb begin
        xfer      = s_valid & s_ready;
        hdr_len   = {s_data, len[7:0]};
        hdr_bad   = (hdr_len == 16'd0) || (hdr_len > 16'(MEM_BYTES));
        last_byte = (({3'b000, bytes_loaded} + 16'd1) == len);
    end

    // State register; cpu_rst_n is registered from the next state so it rises together with load_done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HDR0;
            cpu_rst_n <= 1'b0;
        end else begin
            state     <= next_state;
            cpu_rst_n <= (next_state == DONE);
        end
    end

    // Next-state logic: header, payload, checksum, then park in DONE or ERR until reload.
    always_comb begin
        next_state = state;
        case (state)
            HDR0: begin
                if (xfer) next_state = HDR1;
            end
            HDR1: begin
                if (xfer) next_state = hdr_bad ? ERR : LOAD;
            end
            LOAD: begin
                if (xfer && last_byte) next_state = CHK;
            end
            CHK: begin
                if (xfer) next_state = (s_data == sum) ? DONE : ERR;
            end
            DONE: begin
                if (reload) next_state = HDR0;
            end
            ERR: begin
                if (reload) next_state = HDR0;
            end
            default: next_state = HDR0;
        endcase
    end

    // Output decode: ready in every accepting state, status flags straight from the state.
    always_comb begin
        s_ready   = 1'b0;
        load_done = 1'b0;
        load_err  = 1'b0;
        case (state)
            HDR0, HDR1, LOAD, CHK: s_ready = 1'b1;
            DONE:                  load_done = 1'b1;
            ERR:                   load_err = 1'b1;
            default:               s_ready = 1'b0;
        endcase
    end

    // Length, running checksum and payload counter; cleared by reset or by a reload from DONE/ERR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len          <= 16'd0;
            sum          <= 8'd0;
            bytes_loaded <= 13'd0;
        end else begin
            case (state)
                HDR0: begin
                    if (xfer) len[7:0] <= s_data;
                end
                HDR1: begin
                    if (xfer) len[15:8] <= s_data;
                end
                LOAD: begin
                    if (xfer) begin
                        sum          <= sum + s_data;
                        bytes_loaded <= bytes_loaded + 13'd1;
                    end
                end
                DONE, ERR: begin
                    if (reload) begin
                        len          <= 16'd0;
                        sum          <= 8'd0;
                        bytes_loaded <= 13'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Payload write port; the memory is never cleared so bytes beyond the current length survive.
    always_ff @(posedge clk) begin
        if (rst_n && (state == LOAD) && xfer) begin
            Instr_memory[bytes_loaded[11:0]] <= s_data;
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader.
// Payload bytes are pushed to a scoreboard queue as they are driven and popped and
// compared against the memory image once the corresponding load has finished.
module tb_instr_mem_loader;

    localparam int MEM_BYTES = 4096;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef logic [7:0] byteq_t [$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        reload = 1'b0;
    logic        s_ready;
    logic [7:0]  instr_memory [0:MEM_BYTES-1];
    logic        load_done;
    logic        load_err;
    logic        cpu_rst_n;
    logic [12:0] bytes_loaded;

    wr_t         expQ [$];
    logic [7:0]  model [0:MEM_BYTES-1];
    int          testsRun = 0;
    int          failCount = 0;
    logic        gapMode = 1'b0;

    instr_mem_loader #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .reload       (reload),
        .Instr_memory (instr_memory),
        .load_done    (load_done),
        .load_err     (load_err),
        .cpu_rst_n    (cpu_rst_n),
        .bytes_loaded (bytes_loaded)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one byte and hold it until a rising edge with s_ready high takes it.
    task automatic applyStimulus(input logic [7:0] b);
        int waited;
        if (gapMode) begin
            while ($urandom_range(0, 9) >= 3) idleCycles(1);
        end
        s_valid = 1'b1;
        s_data  = b;
        waited  = 0;
        while (!s_ready && waited < 20) begin
            idleCycles(1);
            waited++;
        end
        if (!s_ready) begin
            checkOutput("s_ready timeout", {31'b0, s_ready}, 32'd1);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    // Header, payload (scoreboarded) and checksum byte.
    task automatic sendImage(input logic [15:0] len, input byteq_t pay, input logic [7:0] chk);
        applyStimulus(len[7:0]);
        applyStimulus(len[15:8]);
        for (int k = 0; k < pay.size(); k++) begin
            expQ.push_back('{addr: 12'(k), data: pay[k]});
            applyStimulus(pay[k]);
        end
        applyStimulus(chk);
    endtask

    task automatic drainScoreboard(input string tag);
        wr_t w;
        while (expQ.size() != 0) begin
            w = expQ.pop_front();
            checkOutput(tag, {24'b0, instr_memory[w.addr]}, {24'b0, w.data});
            model[w.addr] = w.data;
        end
    endtask

    task automatic checkFlags(input string tag, input logic done, input logic err,
                              input logic cpu, input logic rdy, input logic [12:0] cnt);
        checkOutput({tag, " load_done"}, {31'b0, load_done}, {31'b0, done});
        checkOutput({tag, " load_err"}, {31'b0, load_err}, {31'b0, err});
        checkOutput({tag, " cpu_rst_n"}, {31'b0, cpu_rst_n}, {31'b0, cpu});
        checkOutput({tag, " s_ready"}, {31'b0, s_ready}, {31'b0, rdy});
        checkOutput({tag, " bytes_loaded"}, {19'b0, bytes_loaded}, {19'b0, cnt});
    endtask

    task automatic pulseReload();
        reload = 1'b1;
        idleCycles(1);
        reload = 1'b0;
    endtask

    initial begin
        byteq_t     pay;
        logic [7:0] chk;
        logic [31:0] word;

        // Reset state
        rst_n = 1'b0;
        idleCycles(2);
        checkFlags("reset", 1'b0, 1'b0, 1'b0, 1'b1, 13'd0);
        rst_n = 1'b1;
        idleCycles(1);

        // Basic image: 0x00500093 at the reset vector
        pay = '{8'h93, 8'h00, 8'h50, 8'h00};
        sendImage(16'd4, pay, 8'hE3);
        checkFlags("basic", 1'b1, 1'b0, 1'b1, 1'b0, 13'd4);
        drainScoreboard("basic mem");
        word = {instr_memory[3], instr_memory[2], instr_memory[1], instr_memory[0]};
        checkOutput("basic fetch word", word, 32'h00500093);
        idleCycles(3);
        checkFlags("basic hold", 1'b1, 1'b0, 1'b1, 1'b0, 13'd4);

        // Bad checksum
        pulseReload();
        checkFlags("reload from done", 1'b0, 1'b0, 1'b0, 1'b1, 13'd0);
        sendImage(16'd4, pay, 8'hE4);
        checkFlags("bad checksum", 1'b0, 1'b1, 1'b0, 1'b0, 13'd4);
        drainScoreboard("bad checksum mem");

        // Zero length header
        pulseReload();
        checkFlags("reload from err", 1'b0, 1'b0, 1'b0, 1'b1, 13'd0);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        checkFlags("len zero", 1'b0, 1'b1, 1'b0, 1'b0, 13'd0);

        // Length 4097
        pulseReload();
        applyStimulus(8'h01);
        applyStimulus(8'h10);
        checkFlags("len 4097", 1'b0, 1'b1, 1'b0, 1'b0, 13'd0);

        // Basic image with random valid gaps
        pulseReload();
        gapMode = 1'b1;
        sendImage(16'd4, pay, 8'hE3);
        gapMode = 1'b0;
        checkFlags("gaps", 1'b1, 1'b0, 1'b1, 1'b0, 13'd4);
        drainScoreboard("gaps mem");

        // Full 4096-byte image, byte k = k mod 256
        pulseReload();
        pay = {};
        chk = 8'h00;
        for (int k = 0; k < MEM_BYTES; k++) begin
            pay.push_back(8'(k));
            chk = chk + 8'(k);
        end
        sendImage(16'd4096, pay, chk);
        checkFlags("full", 1'b1, 1'b0, 1'b1, 1'b0, 13'h1000);
        checkOutput("full mem[4095]", {24'b0, instr_memory[4095]}, 32'hFF);
        drainScoreboard("full mem");

        // Reset after two payload bytes; a byte presented with rst_n low is dropped
        pulseReload();
        applyStimulus(8'h04);
        applyStimulus(8'h00);
        expQ.push_back('{addr: 12'd0, data: 8'h93});
        applyStimulus(8'h93);
        expQ.push_back('{addr: 12'd1, data: 8'h00});
        applyStimulus(8'h00);
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h50;
        idleCycles(1);
        s_valid = 1'b0;
        rst_n   = 1'b1;
        checkFlags("mid-load reset", 1'b0, 1'b0, 1'b0, 1'b1, 13'd0);
        drainScoreboard("mid-load reset mem");
        checkOutput("reset keeps mem[2]", {24'b0, instr_memory[2]}, {24'b0, model[2]});
        pay = '{8'h93, 8'h00, 8'h50, 8'h00};
        sendImage(16'd4, pay, 8'hE3);
        checkFlags("after reset", 1'b1, 1'b0, 1'b1, 1'b0, 13'd4);
        drainScoreboard("after reset mem");

        // Reload then a two-byte image leaves mem[2..] alone
        pulseReload();
        pay = '{8'hAA, 8'hBB};
        sendImage(16'd2, pay, 8'h65);
        checkFlags("reload len2", 1'b1, 1'b0, 1'b1, 1'b0, 13'd2);
        drainScoreboard("reload len2 mem");
        for (int a = 2; a < 6; a++) begin
            checkOutput("reload len2 untouched", {24'b0, instr_memory[a]}, {24'b0, model[a]});
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
